// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment counter monitor: active-low digit patterns,
// FSM state type and pattern decode/encode helpers.
package seg7_pkg;

    localparam logic [6:0] SEG_D0    = 7'b1000000;
    localparam logic [6:0] SEG_D1    = 7'b1111001;
    localparam logic [6:0] SEG_D2    = 7'b0100100;
    localparam logic [6:0] SEG_D3    = 7'b0110000;
    localparam logic [6:0] SEG_D4    = 7'b0011001;
    localparam logic [6:0] SEG_D5    = 7'b0010010;
    localparam logic [6:0] SEG_D6    = 7'b0000010;
    localparam logic [6:0] SEG_D7    = 7'b1111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } mon_state_e;

    typedef struct packed {
        logic       ok;
        logic [2:0] digit;
    } seg7_dec_t;

    // Digits at or above the modulus are treated as undecodable.
    function automatic seg7_dec_t seg7_decode(input logic [6:0] pat, input int unsigned modulus);
        seg7_dec_t r;
        r.ok    = 1'b1;
        r.digit = 3'd0;
        case (pat)
            SEG_D0:  r.digit = 3'd0;
            SEG_D1:  r.digit = 3'd1;
            SEG_D2:  r.digit = 3'd2;
            SEG_D3:  r.digit = 3'd3;
            SEG_D4:  r.digit = 3'd4;
            SEG_D5:  r.digit = 3'd5;
            SEG_D6:  r.digit = 3'd6;
            SEG_D7:  r.digit = 3'd7;
            default: r.ok    = 1'b0;
        endcase
        if (r.ok && (32'(r.digit) >= modulus)) r.ok = 1'b0;
        return r;
    endfunction

    function automatic logic [6:0] seg7_encode(input logic [2:0] d);
        logic [6:0] p;
        case (d)
            3'd0:    p = SEG_D0;
            3'd1:    p = SEG_D1;
            3'd2:    p = SEG_D2;
            3'd3:    p = SEG_D3;
            3'd4:    p = SEG_D4;
            3'd5:    p = SEG_D5;
            3'd6:    p = SEG_D6;
            default: p = SEG_D7;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Synchronizes the asynchronous segment bus, waits for it to hold steady for
// STABLE_CYCLES and strobes once per newly accepted pattern.
module seg7_stable_filter #(
    parameter int STABLE_CYCLES = 1000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [6:0] seg_i,
    output logic       accept_stb,
    output logic [6:0] pattern
);

    localparam int             CW      = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [6:0]    s1_q, s2_q;
    logic [6:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    last_q;
    logic          last_vld_q;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // last_vld_q stands in for "nothing accepted yet", so any first pattern is new.
    assign accept_stb = (cnt_q == CNT_MAX) && (!last_vld_q || (cand_q != last_q));
    assign pattern    = cand_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_q       <= '0;
            s2_q       <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            s1_q   <= seg_i;
            s2_q   <= s1_q;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            if (accept_stb) begin
                last_q     <= cand_q;
                last_vld_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_count_monitor.sv
// Receive-side checker for a 7-segment up-counter link: filters, decodes and checks the digit
// sequence. Define SEG7_MON_ECHO_EN to add the registered HEX0 echo output.
//
// state | meaning
// IDLE  | nothing decodable accepted since reset
// TRACK | locked to the count, each new digit checked against previous+1
// ERROR | last accepted pattern was undecodable
module seg7_count_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000,
    parameter int MOD           = 8,
    parameter int ERR_W         = 8
) (
    input  logic             CLOCK_50,
    input  logic             KEY0,
    input  logic [6:0]       seg_in,
    output logic [2:0]       value,
    output logic             valid,
    output logic             invalid,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
`ifdef SEG7_MON_ECHO_EN
    ,
    output logic [6:0]       HEX0
`endif
);

    localparam logic [2:0] LAST_DIGIT = 3'(MOD - 1);

    logic       accept_stb;
    logic [6:0] pattern;
    seg7_dec_t  dec;
    logic [2:0] next_digit;
    logic       err_sat;

    mon_state_e       state_q;
    logic [2:0]       value_q;
    logic             valid_q;
    logic             invalid_q;
    logic             seq_err_q;
    logic [ERR_W-1:0] err_q;
`ifdef SEG7_MON_ECHO_EN
    logic [6:0]       hex_q;
`endif

    seg7_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk_i      (CLOCK_50),
        .rst_n_i    (KEY0),
        .seg_i      (seg_in),
        .accept_stb (accept_stb),
        .pattern    (pattern)
    );

    assign dec        = seg7_decode(pattern, MOD);
    assign next_digit = (value_q == LAST_DIGIT) ? 3'd0 : value_q + 3'd1;
    assign err_sat    = &err_q;

    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            state_q   <= IDLE;
            value_q   <= '0;
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
            seq_err_q <= 1'b0;
            err_q     <= '0;
`ifdef SEG7_MON_ECHO_EN
            hex_q     <= SEG_BLANK;
`endif
        end else begin
            valid_q   <= 1'b0;
            seq_err_q <= 1'b0;
            if (accept_stb) begin
                if (dec.ok) begin
                    state_q   <= TRACK;
                    value_q   <= dec.digit;
                    valid_q   <= 1'b1;
                    invalid_q <= 1'b0;
`ifdef SEG7_MON_ECHO_EN
                    hex_q     <= seg7_encode(dec.digit);
`endif
                    // Only a locked monitor checks continuity; re-entry from IDLE/ERROR resyncs silently.
                    if ((state_q == TRACK) && (dec.digit != next_digit)) begin
                        seq_err_q <= 1'b1;
                        if (!err_sat) err_q <= err_q + 1'b1;
                    end
                end else begin
                    state_q   <= ERROR;
                    invalid_q <= 1'b1;
                    if (!err_sat) err_q <= err_q + 1'b1;
`ifdef SEG7_MON_ECHO_EN
                    hex_q     <= SEG_DASH;
`endif
                end
            end
        end
    end

    assign value     = value_q;
    assign valid     = valid_q;
    assign invalid   = invalid_q;
    assign seq_err   = seq_err_q;
    assign locked    = (state_q == TRACK);
    assign err_count = err_q;
`ifdef SEG7_MON_ECHO_EN
    assign HEX0      = hex_q;
`endif

endmodule

// File: tb/tb_seg7_count_monitor.sv
// Scoreboard bench for seg7_count_monitor: a segment-level reference model predicts every
// accepted pattern and the monitor process compares each observed output event in order.
module tb_seg7_count_monitor;

    localparam int STABLE  = 4;
    localparam int MOD     = 8;
    localparam int ERR_W   = 2;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    logic             clk = 1'b0;
    logic             key0 = 1'b0;
    logic [6:0]       seg_in = 7'b1111111;
    logic [2:0]       value;
    logic             valid;
    logic             invalid;
    logic             seq_err;
    logic             locked;
    logic [ERR_W-1:0] err_count;
`ifdef SEG7_MON_ECHO_EN
    logic [6:0]       hex0;
`endif

    always #5 clk = ~clk;

    seg7_count_monitor #(
        .STABLE_CYCLES (STABLE),
        .MOD           (MOD),
        .ERR_W         (ERR_W)
    ) dut (
        .CLOCK_50  (clk),
        .KEY0      (key0),
        .seg_in    (seg_in),
        .value     (value),
        .valid     (valid),
        .invalid   (invalid),
        .seq_err   (seq_err),
        .locked    (locked),
        .err_count (err_count)
`ifdef SEG7_MON_ECHO_EN
        ,
        .HEX0      (hex0)
`endif
    );

    typedef struct packed {
        logic [2:0]       value;
        logic             valid;
        logic             invalid;
        logic             seq_err;
        logic             locked;
        logic [ERR_W-1:0] err;
        logic [6:0]       hex;
    } obs_t;

    logic [6:0] tbl [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

    int   vectors = 0;
    int   miscompares = 0;
    obs_t exp_q[$];

    int         m_value, m_locked, m_invalid, m_err, m_last;
    logic [6:0] m_hex;

    bit               mon_en = 1'b0;
    logic             p_invalid = 1'b0;
    logic             p_locked = 1'b0;
    logic [ERR_W-1:0] p_err = '0;

    function automatic obs_t sample();
        obs_t o;
        o.value   = value;
        o.valid   = valid;
        o.invalid = invalid;
        o.seq_err = seq_err;
        o.locked  = locked;
        o.err     = err_count;
`ifdef SEG7_MON_ECHO_EN
        o.hex     = hex0;
`else
        o.hex     = 7'h00;
`endif
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_value = 0; m_locked = 0; m_invalid = 0; m_err = 0; m_last = -1; m_hex = BLANK;
    endtask

    // One accepted pattern: digit lookup by table, counting rules applied with plain arithmetic.
    task automatic model_accept(input logic [6:0] p);
        int   d;
        int   old_inv, old_lock, old_err;
        bit   seq;
        obs_t e;
        d = -1;
        seq = 1'b0;
        old_inv = m_invalid; old_lock = m_locked; old_err = m_err;
        for (int i = 0; i < MOD; i++) if (tbl[i] == p) d = i;
        if (d >= 0) begin
            seq = (m_locked != 0) && (d != (m_value + 1) % MOD);
            if (seq && m_err < ERR_MAX) m_err++;
            m_locked = 1; m_value = d; m_invalid = 0; m_hex = tbl[d];
        end else begin
            m_invalid = 1; m_locked = 0; m_hex = DASH;
            if (m_err < ERR_MAX) m_err++;
        end
        m_last = int'(p);
        e.value   = 3'(m_value);
        e.valid   = (d >= 0);
        e.invalid = (m_invalid != 0);
        e.seq_err = seq;
        e.locked  = (m_locked != 0);
        e.err     = ERR_W'(m_err);
`ifdef SEG7_MON_ECHO_EN
        e.hex     = m_hex;
`else
        e.hex     = 7'h00;
`endif
        if (d >= 0 || m_invalid != old_inv || m_locked != old_lock || m_err != old_err)
            exp_q.push_back(e);
    endtask

    // A pattern held for at least STABLE edges is accepted unless it repeats the last accepted one.
    task automatic apply_seg(input logic [6:0] p, input int h);
        if (h >= STABLE && int'(p) != m_last) model_accept(p);
        seg_in = p;
        repeat (h) @(posedge clk);
        #2;
    endtask

    task automatic drain_check(input string name);
        repeat (12) @(posedge clk);
        #2;
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        key0 = 1'b0;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        check("rst_value", value, 0);
        check("rst_valid", valid, 0);
        check("rst_invalid", invalid, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_locked", locked, 0);
        check("rst_err_count", err_count, 0);
`ifdef SEG7_MON_ECHO_EN
        check("rst_hex0", hex0, BLANK);
`endif
        #1;
        key0 = 1'b1;
        exp_q.delete();
        model_reset();
        p_invalid = 1'b0; p_locked = 1'b0; p_err = '0;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        obs_t c, e;
        c = sample();
        if (mon_en && (c.valid || c.invalid != p_invalid || c.locked != p_locked || c.err != p_err)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got value=%0d valid=%0b invalid=%0b seq_err=%0b locked=%0b err=%0d, required no event",
                         c.value, c.valid, c.invalid, c.seq_err, c.locked, c.err);
            end else begin
                e = exp_q.pop_front();
                if (c !== e) begin
                    miscompares++;
                    $display("FAIL accept_event: got value=%0d valid=%0b invalid=%0b seq_err=%0b locked=%0b err=%0d hex=%07b, required value=%0d valid=%0b invalid=%0b seq_err=%0b locked=%0b err=%0d hex=%07b",
                             c.value, c.valid, c.invalid, c.seq_err, c.locked, c.err, c.hex,
                             e.value, e.valid, e.invalid, e.seq_err, e.locked, e.err, e.hex);
                end
            end
        end
        p_invalid = c.invalid;
        p_locked  = c.locked;
        p_err     = c.err;
    end

    initial begin
        int         first;
        logic [6:0] p;
        int         h, r;

        model_reset();
        repeat (2) @(posedge clk);
        #2;
        do_reset();

        // Latency: first valid after edge STABLE+3 of a held pattern.
        first = 0;
        model_accept(tbl[0]);
        seg_in = tbl[0];
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (valid && first == 0) first = k;
            #1;
        end
        check("latency_edge", first, STABLE + 3);

        for (int d = 1; d <= 8; d++) apply_seg(tbl[d % 8], 10);
        drain_check("count_drain");
        check("count_err", err_count, 0);
        check("count_value", value, 0);

        apply_seg(tbl[2], 10);
        drain_check("skip_drain");
        check("skip_err", err_count, 1);
        check("skip_value", value, 2);
        check("skip_locked", locked, 1);

        apply_seg(tbl[1], 10);
        apply_seg(tbl[2], 2);
        apply_seg(tbl[1], 10);
        drain_check("glitch_drain");
        check("glitch_value", value, 1);
        check("glitch_err", err_count, 2);

        do_reset();
        apply_seg(tbl[0], 8);
        apply_seg(BLANK, 8);
        drain_check("blank_drain");
        check("blank_invalid", invalid, 1);
        check("blank_locked", locked, 0);
        apply_seg(tbl[3], 8);
        drain_check("recover_drain");
        check("recover_value", value, 3);
        check("recover_invalid", invalid, 0);
        check("recover_locked", locked, 1);
        check("recover_err", err_count, 1);

        for (int i = 0; i < 5; i++) begin
            apply_seg(BLANK, 6);
            apply_seg(tbl[(i + 4) % 8], 6);
        end
        drain_check("sat_drain");
        check("sat_err", err_count, ERR_MAX);

        for (int n = 0; n < 80; n++) begin
            do begin
                r = $urandom_range(0, 9);
                if (r < 4)       p = tbl[(m_value + 1) % MOD];
                else if (r < 7)  p = tbl[$urandom_range(0, 7)];
                else if (r == 7) p = BLANK;
                else             p = 7'($urandom_range(1, 127));
            end while (p == seg_in);
            h = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 12);
            apply_seg(p, h);
            if (n == 40) do_reset();
        end
        apply_seg((seg_in != BLANK) ? BLANK : tbl[0], 15);
        drain_check("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
